// File: rtl/bpred_pkg.sv
// rtl/bpred_pkg.sv - shared types, constants and slice helpers for the branch target buffer
// Entry fields are sized for the largest legal parameters (TAG_BITS 20, CTR_BITS 4,
// XLEN 64); users write and read only the low bits they need, so the rest stay zero.
package bpred_pkg;

    localparam int MAX_TAG_BITS = 20;
    localparam int MAX_CTR_BITS = 4;
    localparam int MAX_XLEN     = 64;

    typedef logic [MAX_CTR_BITS-1:0] ctr_t;

    typedef struct packed {
        logic                    valid;
        logic [MAX_TAG_BITS-1:0] tag;
        logic [MAX_XLEN-1:0]     target;
        ctr_t                    ctr;
    } btb_entry_t;

    typedef enum logic [1:0] {
        CTR_INC      = 2'd0,
        CTR_DEC      = 2'd1,
        CTR_SET_MAX  = 2'd2,
        CTR_SET_WEAK = 2'd3
    } ctr_op_e;

    // Counter constants for a counter of the given width.
    function automatic ctr_t ctr_max(input int bits);
        return ctr_t'((1 << bits) - 1);
    endfunction

    function automatic ctr_t ctr_weak_t(input int bits);
        return ctr_t'(1 << (bits - 1));
    endfunction

    function automatic ctr_t ctr_weak_nt(input int bits);
        return ctr_t'((1 << (bits - 1)) - 1);
    endfunction

    // Saturating step: never wraps past 0 or the width's maximum.
    function automatic ctr_t ctr_sat(input ctr_t ctr, input logic inc, input int bits);
        if (inc) begin
            return (ctr == ctr_max(bits)) ? ctr : ctr + ctr_t'(1);
        end
        return (ctr == '0) ? ctr : ctr - ctr_t'(1);
    endfunction

    // Index is pc[IDX_BITS+1:2]; word-aligned PCs, so bits [1:0] are skipped.
    function automatic logic [7:0] pc_index(input logic [MAX_XLEN-1:0] pc, input int idx_bits);
        return 8'((pc >> 2) & ((64'd1 << idx_bits) - 64'd1));
    endfunction

    // Tag is the TAG_BITS immediately above the index.
    function automatic logic [MAX_TAG_BITS-1:0] pc_tag(input logic [MAX_XLEN-1:0] pc,
                                                       input int idx_bits,
                                                       input int tag_bits);
        logic [MAX_TAG_BITS-1:0] raw;
        raw = MAX_TAG_BITS'(pc >> (idx_bits + 2));
        return raw & ((MAX_TAG_BITS'(1) << tag_bits) - MAX_TAG_BITS'(1));
    endfunction

endpackage

// File: rtl/bpred_sat_ctr.sv
// rtl/bpred_sat_ctr.sv - next-value logic for one saturating direction counter
// Ports: ctr_cur (current value), op (inc/dec/set-max/set-weak-taken), ctr_next (result).
module bpred_sat_ctr
    import bpred_pkg::*;
#(
    parameter int CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] ctr_cur,
    input  ctr_op_e             op,
    output logic [CTR_BITS-1:0] ctr_next
);

    ctr_t cur_ext;
    ctr_t nxt_ext;

    always_comb begin
        cur_ext = ctr_t'(ctr_cur);
        nxt_ext = cur_ext;
        unique case (op)
            CTR_INC:      nxt_ext = ctr_sat(cur_ext, 1'b1, CTR_BITS);
            CTR_DEC:      nxt_ext = ctr_sat(cur_ext, 1'b0, CTR_BITS);
            CTR_SET_MAX:  nxt_ext = ctr_max(CTR_BITS);
            CTR_SET_WEAK: nxt_ext = ctr_weak_t(CTR_BITS);
            default:      nxt_ext = cur_ext;
        endcase
        ctr_next = CTR_BITS'(nxt_ext);
    end

endmodule

// File: rtl/bpred_btb.sv
// rtl/bpred_btb.sv - direct-mapped branch target buffer with saturating direction counters
// Ports: lookup_pc -> pred_hit/pred_taken/pred_target (combinational lookup);
//        upd_* resolved branch/jump write-back, one per cycle; flush_all clears valid bits;
//        perf_updates/perf_mispredicts free-running event counters.
module bpred_btb
    import bpred_pkg::*;
#(
    parameter int ENTRIES  = 16,
    parameter int TAG_BITS = 8,
    parameter int CTR_BITS = 2,
    parameter int XLEN     = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic            upd_is_jump,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_pred_taken,
    input  logic [XLEN-1:0] upd_pred_target,
    input  logic            flush_all,
    output logic [31:0]     perf_updates,
    output logic [31:0]     perf_mispredicts
);

    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam btb_entry_t RESET_ENTRY = '{
        valid:  1'b0,
        tag:    '0,
        target: '0,
        ctr:    ctr_weak_nt(CTR_BITS)
    };

    // Flops rather than SRAM so the whole table clears on asynchronous reset.
    btb_entry_t entries [ENTRIES];

    logic [IDX_BITS-1:0]     lk_idx;
    logic [MAX_TAG_BITS-1:0] lk_tag;
    logic [IDX_BITS-1:0]     upd_idx;
    logic [MAX_TAG_BITS-1:0] upd_tag;
    logic                    upd_hit;
    logic                    upd_write;
    logic                    mispredict;
    ctr_op_e                 ctr_op;
    logic [CTR_BITS-1:0]     ctr_next;
    btb_entry_t              upd_entry;

    // Lookup reads registered state only; a same-cycle update is not forwarded.
    always_comb begin
        lk_idx      = IDX_BITS'(pc_index(MAX_XLEN'(lookup_pc), IDX_BITS));
        lk_tag      = pc_tag(MAX_XLEN'(lookup_pc), IDX_BITS, TAG_BITS);
        pred_hit    = entries[lk_idx].valid && (entries[lk_idx].tag == lk_tag);
        pred_taken  = pred_hit && entries[lk_idx].ctr[CTR_BITS-1];
        pred_target = pred_hit ? XLEN'(entries[lk_idx].target) : '0;
    end

    always_comb begin
        upd_idx = IDX_BITS'(pc_index(MAX_XLEN'(upd_pc), IDX_BITS));
        upd_tag = pc_tag(MAX_XLEN'(upd_pc), IDX_BITS, TAG_BITS);
        upd_hit = entries[upd_idx].valid && (entries[upd_idx].tag == upd_tag);

        // A miss only allocates when taken; a jump always lands on max confidence.
        if (upd_is_jump) begin
            ctr_op = CTR_SET_MAX;
        end else if (!upd_hit) begin
            ctr_op = CTR_SET_WEAK;
        end else if (upd_taken) begin
            ctr_op = CTR_INC;
        end else begin
            ctr_op = CTR_DEC;
        end

        upd_write  = upd_valid && !flush_all && (upd_hit || upd_taken);
        mispredict = upd_valid && ((upd_taken != upd_pred_taken) ||
                                   (upd_taken && (upd_target != upd_pred_target)));
    end

    bpred_sat_ctr #(
        .CTR_BITS (CTR_BITS)
    ) u_sat_ctr (
        .ctr_cur  (entries[upd_idx].ctr[CTR_BITS-1:0]),
        .op       (ctr_op),
        .ctr_next (ctr_next)
    );

    always_comb begin
        upd_entry       = entries[upd_idx];
        upd_entry.valid = 1'b1;
        upd_entry.tag   = upd_tag;
        if (upd_is_jump || upd_taken) begin
            upd_entry.target = MAX_XLEN'(upd_target);
        end
        upd_entry.ctr = ctr_t'(ctr_next);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries[i] <= RESET_ENTRY;
            end
            perf_updates     <= '0;
            perf_mispredicts <= '0;
        end else begin
            // Flush beats a same-cycle write for entry state; counters and targets survive.
            if (flush_all) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    entries[i].valid <= 1'b0;
                end
            end else if (upd_write) begin
                entries[upd_idx] <= upd_entry;
            end
            if (upd_valid) begin
                perf_updates <= perf_updates + 32'd1;
            end
            if (mispredict) begin
                perf_mispredicts <= perf_mispredicts + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_bpred_btb.sv
// tb/tb_bpred_btb.sv - self-checking bench for bpred_btb
module tb_bpred_btb;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] lookup_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_is_jump;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        flush_all;
    logic [31:0] perf_updates;
    logic [31:0] perf_mispredicts;

    always #5 clk = ~clk;

    bpred_btb dut (
        .clk              (clk),
        .reset            (reset),
        .lookup_pc        (lookup_pc),
        .pred_hit         (pred_hit),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_is_jump      (upd_is_jump),
        .upd_target       (upd_target),
        .upd_pred_taken   (upd_pred_taken),
        .upd_pred_target  (upd_pred_target),
        .flush_all        (flush_all),
        .perf_updates     (perf_updates),
        .perf_mispredicts (perf_mispredicts)
    );

    typedef struct {
        string       name;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic        uj;
        logic [31:0] utgt;
        logic        upt;
        logic [31:0] uptgt;
        logic        fl;
        logic [31:0] lpc;
        logic        e_hit;
        logic        e_taken;
        logic [31:0] e_tgt;
        logic [31:0] e_upd;
        logic [31:0] e_mis;
    } vec_t;

    typedef struct {
        string       name;
        logic        hit;
        logic        taken;
        logic [31:0] tgt;
        logic [31:0] upd;
        logic [31:0] mis;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(string name, logic uv, logic [31:0] upc, logic ut, logic uj,
                                logic [31:0] utgt, logic upt, logic [31:0] uptgt, logic fl,
                                logic [31:0] lpc, logic e_hit, logic e_taken,
                                logic [31:0] e_tgt, logic [31:0] e_upd, logic [31:0] e_mis);
        vec_t v;
        v.name = name; v.uv = uv; v.upc = upc; v.ut = ut; v.uj = uj; v.utgt = utgt;
        v.upt = upt; v.uptgt = uptgt; v.fl = fl; v.lpc = lpc; v.e_hit = e_hit;
        v.e_taken = e_taken; v.e_tgt = e_tgt; v.e_upd = e_upd; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic push_exp(string name, logic hit, logic taken, logic [31:0] tgt,
                            logic [31:0] upd, logic [31:0] mis);
        exp_t e;
        e.name = name; e.hit = hit; e.taken = taken; e.tgt = tgt; e.upd = upd; e.mis = mis;
        sb_q.push_back(e);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic compare_front();
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: got empty queue expected an entry");
            return;
        end
        e = sb_q.pop_front();
        chk({e.name, ".pred_hit"},         32'(pred_hit),   32'(e.hit));
        chk({e.name, ".pred_taken"},       32'(pred_taken), 32'(e.taken));
        chk({e.name, ".pred_target"},      pred_target,     e.tgt);
        chk({e.name, ".perf_updates"},     perf_updates,    e.upd);
        chk({e.name, ".perf_mispredicts"}, perf_mispredicts, e.mis);
    endtask

    task automatic idle_inputs();
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_is_jump = 1'b0;
        upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0; flush_all = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        lookup_pc = 32'h40;
        idle_inputs();

        //            name        uv  upc       ut  uj  utgt      upt uptgt     fl  lpc      hit tk  tgt       upd mis
        vecs.push_back(mk("reset",   0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h40,  0, 0, 32'h0,   0,  0));
        vecs.push_back(mk("alloc",   1, 32'h40,  1, 0, 32'h100, 0, 32'h0,   0, 32'h40,  1, 1, 32'h100, 1,  1));
        vecs.push_back(mk("nt1",     1, 32'h40,  0, 0, 32'h0,   1, 32'h100, 0, 32'h40,  1, 0, 32'h100, 2,  2));
        vecs.push_back(mk("nt2",     1, 32'h40,  0, 0, 32'h0,   0, 32'h0,   0, 32'h40,  1, 0, 32'h100, 3,  2));
        vecs.push_back(mk("nt_sat",  1, 32'h40,  0, 0, 32'h0,   0, 32'h0,   0, 32'h40,  1, 0, 32'h100, 4,  2));
        vecs.push_back(mk("tk1",     1, 32'h40,  1, 0, 32'h100, 0, 32'h0,   0, 32'h40,  1, 0, 32'h100, 5,  3));
        vecs.push_back(mk("tk2",     1, 32'h40,  1, 0, 32'h104, 0, 32'h0,   0, 32'h40,  1, 1, 32'h104, 6,  4));
        vecs.push_back(mk("tk3",     1, 32'h40,  1, 0, 32'h104, 1, 32'h104, 0, 32'h40,  1, 1, 32'h104, 7,  4));
        vecs.push_back(mk("tk4",     1, 32'h40,  1, 0, 32'h104, 1, 32'h104, 0, 32'h40,  1, 1, 32'h104, 8,  4));
        vecs.push_back(mk("sat_hi",  1, 32'h40,  0, 0, 32'h0,   1, 32'h104, 0, 32'h40,  1, 1, 32'h104, 9,  5));
        vecs.push_back(mk("alias",   1, 32'h440, 1, 0, 32'h300, 0, 32'h0,   0, 32'h40,  0, 0, 32'h0,   10, 6));
        vecs.push_back(mk("alias_lk",0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h440, 1, 1, 32'h300, 10, 6));
        vecs.push_back(mk("nt_miss", 1, 32'h840, 0, 0, 32'h0,   0, 32'h0,   0, 32'h440, 1, 1, 32'h300, 11, 6));
        vecs.push_back(mk("flush_j", 1, 32'h80,  1, 1, 32'h200, 0, 32'h0,   1, 32'h80,  0, 0, 32'h0,   12, 7));
        vecs.push_back(mk("flushed", 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 32'h440, 0, 0, 32'h0,   12, 7));
        vecs.push_back(mk("jump",    1, 32'h80,  1, 1, 32'h200, 1, 32'h200, 0, 32'h80,  1, 1, 32'h200, 13, 7));
        vecs.push_back(mk("jump_max",1, 32'h80,  0, 0, 32'h0,   1, 32'h200, 0, 32'h80,  1, 1, 32'h200, 14, 8));
        vecs.push_back(mk("tgt_mis", 1, 32'h80,  1, 0, 32'h204, 1, 32'h200, 0, 32'h80,  1, 1, 32'h204, 15, 9));

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            upd_valid = vecs[i].uv; upd_pc = vecs[i].upc; upd_taken = vecs[i].ut;
            upd_is_jump = vecs[i].uj; upd_target = vecs[i].utgt;
            upd_pred_taken = vecs[i].upt; upd_pred_target = vecs[i].uptgt;
            flush_all = vecs[i].fl; lookup_pc = vecs[i].lpc;
            push_exp(vecs[i].name, vecs[i].e_hit, vecs[i].e_taken, vecs[i].e_tgt,
                     vecs[i].e_upd, vecs[i].e_mis);
            @(posedge clk);
            #1;
            idle_inputs();
            #1;
            compare_front();
        end

        // No bypass: same-cycle lookup of a pending update still misses.
        @(negedge clk);
        upd_valid = 1'b1; upd_pc = 32'hC4; upd_taken = 1'b1; upd_target = 32'h400;
        lookup_pc = 32'hC4;
        #1;
        push_exp("no_bypass", 0, 0, 32'h0, 15, 9);
        compare_front();
        @(posedge clk);
        #1;
        idle_inputs();
        #1;
        push_exp("after_write", 1, 1, 32'h400, 16, 10);
        compare_front();

        // Asynchronous reset in the middle of an update cycle.
        @(negedge clk);
        upd_valid = 1'b1; upd_pc = 32'h48; upd_taken = 1'b1; upd_target = 32'h500;
        lookup_pc = 32'hC4;
        #2;
        reset = 1'b1;
        #1;
        push_exp("async_rst", 0, 0, 32'h0, 0, 0);
        compare_front();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        lookup_pc = 32'h48;
        @(posedge clk);
        #1;
        push_exp("rst_no_write", 0, 0, 32'h0, 0, 0);
        compare_front();
        lookup_pc = 32'hC4;
        #1;
        push_exp("rst_cleared", 0, 0, 32'h0, 0, 0);
        compare_front();

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
